// File: rtl/adc_cap_pkg.sv
// rtl/adc_cap_pkg.sv - shared types and helpers for the ADC event capture block
package adc_cap_pkg;

  typedef enum logic [2:0] {ARM, IDLE, CAPTURE, TAIL, DRAIN} state_t;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Increment that sticks at the all-ones value of a w-bit counter
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/adc_event_capture_if.sv
// rtl/adc_event_capture_if.sv - framed sample stream toward readout
interface adc_event_capture_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              out_trunc;

  modport master (output out_data, output out_valid, output out_last, output out_trunc,
                  input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, input out_trunc,
                  output out_ready);
endinterface

// File: rtl/adc_cap_ring.sv
// rtl/adc_cap_ring.sv - ring storage, one write port and one registered read port
module adc_cap_ring #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int AW     = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/adc_event_capture.sv
// rtl/adc_event_capture.sv - threshold event capture with pre/post history and framed drain
module adc_event_capture
  import adc_cap_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int THRESHOLD = 0,
  parameter int PRE       = 2,
  parameter int POST      = 2,
  parameter int BUF_DEPTH = 32,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DATA_W-1:0]  adc_data,
  adc_event_capture_if.master out,
  output logic               busy,
  output logic [CNT_W-1:0]   frame_cnt,
  output logic [CNT_W-1:0]   drop_cnt
);
  localparam int AW = addr_w(BUF_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0]     DEPTH_L = LW'(BUF_DEPTH);
  localparam logic [DATA_W-1:0] TH      = DATA_W'(THRESHOLD);

  state_t            state, state_n;
  logic [DATA_W-1:0] s, prev, rdata;
  logic [AW-1:0]     wr_ptr, rd_ptr, start, arm_cnt;
  logic [LW-1:0]     len, len_n, rem;
  logic [3:0]        tail, tail_n;
  logic              trunc, active, trig, wr_en, close;
  logic              issue, move, r_valid, r_last, done;

  assign active = s > TH;
  assign trig   = active && !(prev > TH);
  assign busy   = (state == CAPTURE) || (state == TAIL) || (state == DRAIN);
  assign done   = out.out_valid && out.out_ready && out.out_last;
  assign move   = r_valid && (!out.out_valid || out.out_ready);
  // Refill the read stage whenever it will be empty after this cycle
  assign issue  = (state == DRAIN) && (rem != '0) && (!r_valid || move);

  always_comb begin
    state_n = state;
    len_n   = len + 1'b1;
    tail_n  = tail;
    wr_en   = 1'b0;
    close   = 1'b0;
    unique case (state)
      ARM: begin
        wr_en = 1'b1;
        if (arm_cnt == AW'(PRE - 1)) state_n = IDLE;
      end
      IDLE: begin
        wr_en = 1'b1;
        len_n = LW'(PRE + 1);
        if (trig) state_n = CAPTURE;
      end
      CAPTURE: begin
        wr_en = 1'b1;
        if (!active) begin
          tail_n  = 4'd1;
          state_n = TAIL;
          if (POST == 1) close = 1'b1;
        end
      end
      TAIL: begin
        wr_en = 1'b1;
        if (active) begin
          tail_n  = 4'd0;
          state_n = CAPTURE;
        end else begin
          tail_n = tail + 1'b1;
          if (tail_n == 4'(POST)) close = 1'b1;
        end
      end
      DRAIN: if (done) state_n = ARM;
      default: state_n = ARM;
    endcase
    if ((state == CAPTURE || state == TAIL) && len_n == DEPTH_L) close = 1'b1;
    if (close) state_n = DRAIN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ARM;
      s             <= '0;
      prev          <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      start         <= '0;
      arm_cnt       <= '0;
      len           <= '0;
      rem           <= '0;
      tail          <= '0;
      trunc         <= 1'b0;
      r_valid       <= 1'b0;
      r_last        <= 1'b0;
      out.out_valid <= 1'b0;
      out.out_data  <= '0;
      out.out_last  <= 1'b0;
      out.out_trunc <= 1'b0;
      frame_cnt     <= '0;
      drop_cnt      <= '0;
    end else begin
      state   <= state_n;
      s       <= adc_data;
      prev    <= s;
      tail    <= tail_n;
      arm_cnt <= (state == ARM) ? arm_cnt + 1'b1 : '0;
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        len    <= len_n;
      end
      if (state == IDLE && trig) begin
        start <= wr_ptr - AW'(PRE);
        trunc <= 1'b0;
      end
      if (close) begin
        trunc  <= (len_n == DEPTH_L);
        rd_ptr <= start;
        rem    <= len_n;
      end
      if (issue) begin
        rd_ptr <= rd_ptr + 1'b1;
        rem    <= rem - 1'b1;
        r_last <= (rem == LW'(1));
      end
      if (issue)     r_valid <= 1'b1;
      else if (move) r_valid <= 1'b0;
      if (move) begin
        out.out_valid <= 1'b1;
        out.out_data  <= rdata;
        out.out_last  <= r_last;
        out.out_trunc <= r_last && trunc;
      end else if (out.out_valid && out.out_ready) begin
        out.out_valid <= 1'b0;
        out.out_last  <= 1'b0;
        out.out_trunc <= 1'b0;
      end
      if (done) frame_cnt <= CNT_W'(sat_inc(32'(frame_cnt), CNT_W));
      if (trig && (state == ARM || state == DRAIN))
        drop_cnt <= CNT_W'(sat_inc(32'(drop_cnt), CNT_W));
    end
  end

  adc_cap_ring #(.DATA_W(DATA_W), .DEPTH(BUF_DEPTH), .AW(AW)) u_ring (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (s),
    .re    (issue),
    .raddr (rd_ptr),
    .rdata (rdata)
  );
endmodule

// File: tb/tb_adc_event_capture.sv
// tb/tb_adc_event_capture.sv - directed self-checking bench for adc_event_capture
module tb_adc_event_capture;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  adc_data = 8'd0;
  logic        busy;
  logic [15:0] frame_cnt, drop_cnt;

  adc_event_capture_if #(.DATA_W(8)) oif ();

  adc_event_capture #(
    .DATA_W(8), .THRESHOLD(0), .PRE(2), .POST(2), .BUF_DEPTH(32), .CNT_W(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .adc_data  (adc_data),
    .out       (oif),
    .busy      (busy),
    .frame_cnt (frame_cnt),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail = 0;
  int         stall_viol = 0;
  logic [7:0] q_data[$];
  bit         q_last[$];
  bit         q_trunc[$];
  bit         stalled = 1'b0;
  logic [7:0] hold_data;
  logic       hold_last, hold_trunc;

  // 10 zeros, 1..7, 10 zeros
  function automatic logic [7:0] pat(input int i);
    int p;
    p = i % 27;
    if (p >= 10 && p < 17) return 8'(p - 9);
    return 8'd0;
  endfunction

  // 0,0,1,2,3,4,5,6,7,0,0
  function automatic logic [7:0] exp_f1(input int k);
    if (k >= 2 && k <= 8) return 8'(k - 1);
    return 8'd0;
  endfunction

  task automatic cycle(input logic [7:0] d, input logic rdy);
    @(negedge clk);
    if (stalled && (oif.out_valid !== 1'b1 || oif.out_data !== hold_data ||
                    oif.out_last !== hold_last || oif.out_trunc !== hold_trunc))
      stall_viol++;
    adc_data = d;
    oif.out_ready = rdy;
    if (oif.out_valid === 1'b1 && rdy) begin
      q_data.push_back(oif.out_data);
      q_last.push_back(oif.out_last);
      q_trunc.push_back(oif.out_trunc);
    end
    stalled    = (oif.out_valid === 1'b1) && !rdy;
    hold_data  = oif.out_data;
    hold_last  = oif.out_last;
    hold_trunc = oif.out_trunc;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    adc_data = 8'd0;
    oif.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    q_data.delete(); q_last.delete(); q_trunc.delete();
    stalled = 1'b0;
    stall_viol = 0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    oif.out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (oif.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", oif.out_valid); end
    n_checks++; if (oif.out_data !== 8'd0) begin n_fail++; $display("FAIL rst_data: got %0d expected 0", oif.out_data); end
    n_checks++; if (oif.out_last !== 1'b0 || oif.out_trunc !== 1'b0) begin n_fail++; $display("FAIL rst_last_trunc: got %b%b expected 00", oif.out_last, oif.out_trunc); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_checks++; if (frame_cnt !== 16'd0 || drop_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_cnts: got %0d/%0d expected 0/0", frame_cnt, drop_cnt); end
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 90; i++) cycle(pat(i), 1'b1);
    n_checks++; if (q_data.size() != 33) begin n_fail++; $display("FAIL t1_beats: got %0d expected 33", q_data.size()); end
    for (int k = 0; k < 33 && k < q_data.size(); k++) begin
      n_checks++; if (q_data[k] !== exp_f1(k % 11)) begin n_fail++; $display("FAIL t1_data[%0d]: got %0d expected %0d", k, q_data[k], exp_f1(k % 11)); end
      n_checks++; if (q_last[k] !== (k % 11 == 10) || q_trunc[k] !== 1'b0) begin n_fail++; $display("FAIL t1_last_trunc[%0d]: got %b%b expected %b0", k, q_last[k], q_trunc[k], (k % 11 == 10)); end
    end
    n_checks++; if (frame_cnt !== 16'd3) begin n_fail++; $display("FAIL t1_frame_cnt: got %0d expected 3", frame_cnt); end
    n_checks++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL t1_drop_cnt: got %0d expected 0", drop_cnt); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 56; i++) cycle(pat(i), (i % 2 == 0));
    n_checks++; if (q_data.size() != 11) begin n_fail++; $display("FAIL t2_beats: got %0d expected 11", q_data.size()); end
    for (int k = 0; k < 11 && k < q_data.size(); k++) begin
      n_checks++; if (q_data[k] !== exp_f1(k) || q_last[k] !== (k == 10)) begin n_fail++; $display("FAIL t2_beat[%0d]: got %0d/%b expected %0d/%b", k, q_data[k], q_last[k], exp_f1(k), (k == 10)); end
    end
    n_checks++; if (stall_viol != 0) begin n_fail++; $display("FAIL t2_stall_stable: got %0d changes expected 0", stall_viol); end
    n_checks++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL t2_frame_cnt: got %0d expected 1", frame_cnt); end
  endtask

  task automatic test_retrigger();
    logic [7:0] stim [10];
    logic [7:0] exp3 [7];
    stim = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd3, 8'd0, 8'd5, 8'd0, 8'd0};
    exp3 = '{8'd0, 8'd0, 8'd3, 8'd0, 8'd5, 8'd0, 8'd0};
    do_reset();
    for (int i = 0; i < 35; i++) cycle((i < 10) ? stim[i] : 8'd0, 1'b1);
    n_checks++; if (q_data.size() != 7) begin n_fail++; $display("FAIL t3_beats: got %0d expected 7", q_data.size()); end
    for (int k = 0; k < 7 && k < q_data.size(); k++) begin
      n_checks++; if (q_data[k] !== exp3[k] || q_last[k] !== (k == 6)) begin n_fail++; $display("FAIL t3_beat[%0d]: got %0d/%b expected %0d/%b", k, q_data[k], q_last[k], exp3[k], (k == 6)); end
    end
    n_checks++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL t3_frame_cnt: got %0d expected 1", frame_cnt); end
  endtask

  task automatic test_truncation();
    logic [7:0] e;
    do_reset();
    for (int i = 0; i < 90; i++) cycle((i >= 5 && i < 45) ? 8'(i - 4) : 8'd0, 1'b1);
    n_checks++; if (q_data.size() != 32) begin n_fail++; $display("FAIL t4_beats: got %0d expected 32", q_data.size()); end
    for (int k = 0; k < 32 && k < q_data.size(); k++) begin
      e = (k < 2) ? 8'd0 : 8'(k - 1);
      n_checks++; if (q_data[k] !== e) begin n_fail++; $display("FAIL t4_data[%0d]: got %0d expected %0d", k, q_data[k], e); end
      n_checks++; if (q_last[k] !== (k == 31) || q_trunc[k] !== (k == 31)) begin n_fail++; $display("FAIL t4_last_trunc[%0d]: got %b%b expected %b%b", k, q_last[k], q_trunc[k], (k == 31), (k == 31)); end
    end
    n_checks++; if (frame_cnt !== 16'd1 || drop_cnt !== 16'd0) begin n_fail++; $display("FAIL t4_cnts: got %0d/%0d expected 1/0", frame_cnt, drop_cnt); end
  endtask

  task automatic test_stall_drops();
    int busy_low;
    busy_low = 0;
    do_reset();
    for (int i = 0; i < 116; i++) begin
      cycle(pat(i), (i >= 100));
      if (i >= 30 && i < 100 && busy !== 1'b1) busy_low++;
    end
    n_checks++; if (busy_low != 0) begin n_fail++; $display("FAIL t5_busy: got %0d low cycles expected 0", busy_low); end
    n_checks++; if (drop_cnt !== 16'd3) begin n_fail++; $display("FAIL t5_drop_cnt: got %0d expected 3", drop_cnt); end
    n_checks++; if (q_data.size() != 11) begin n_fail++; $display("FAIL t5_beats: got %0d expected 11", q_data.size()); end
    for (int k = 0; k < 11 && k < q_data.size(); k++) begin
      n_checks++; if (q_data[k] !== exp_f1(k) || q_last[k] !== (k == 10)) begin n_fail++; $display("FAIL t5_beat[%0d]: got %0d/%b expected %0d/%b", k, q_data[k], q_last[k], exp_f1(k), (k == 10)); end
    end
    n_checks++; if (stall_viol != 0) begin n_fail++; $display("FAIL t5_stall_stable: got %0d changes expected 0", stall_viol); end
    n_checks++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL t5_frame_cnt: got %0d expected 1", frame_cnt); end
  endtask

  task automatic test_reset_mid_drain();
    int lasts;
    lasts = 0;
    do_reset();
    for (int i = 0; i < 26; i++) cycle(pat(i), 1'b0);
    n_checks++; if (oif.out_valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL t6_pre_valid_busy: got %b%b expected 11", oif.out_valid, busy); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (oif.out_valid !== 1'b0 || oif.out_last !== 1'b0 || oif.out_data !== 8'd0) begin n_fail++; $display("FAIL t6_async_clear: got v%b l%b d%0d expected v0 l0 d0", oif.out_valid, oif.out_last, oif.out_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t6_async_busy: got %b expected 0", busy); end
    repeat (2) @(negedge clk);
    q_data.delete(); q_last.delete(); q_trunc.delete();
    stalled = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 45; i++) cycle(pat(i), 1'b1);
    n_checks++; if (q_data.size() != 11) begin n_fail++; $display("FAIL t6_beats: got %0d expected 11", q_data.size()); end
    for (int k = 0; k < 11 && k < q_data.size(); k++) begin
      if (q_last[k]) lasts++;
      n_checks++; if (q_data[k] !== exp_f1(k)) begin n_fail++; $display("FAIL t6_data[%0d]: got %0d expected %0d", k, q_data[k], exp_f1(k)); end
    end
    n_checks++; if (lasts != 1) begin n_fail++; $display("FAIL t6_last_count: got %0d expected 1", lasts); end
    n_checks++; if (frame_cnt !== 16'd1 || drop_cnt !== 16'd0) begin n_fail++; $display("FAIL t6_cnts: got %0d/%0d expected 1/0", frame_cnt, drop_cnt); end
  endtask

  initial begin
    oif.out_ready = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_retrigger();
    test_truncation();
    test_stall_drops();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
